// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: arbitrates the register-file write port between WB, a mult/div
// result FIFO and a debug port (debug arbitration enabled by RF_ARB_DBG_PORT_EN).
module rf_write_arbiter #(
  parameter int FIFO_DEPTH  = 2,
  parameter int STALL_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_we,
  input  logic [4:0]  wb_wa,
  input  logic [31:0] wb_wd,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_wa,
  input  logic [31:0] md_wd,
  input  logic        dbg_valid,
  output logic        dbg_ready,
  input  logic [4:0]  dbg_wa,
  input  logic [31:0] dbg_wd,
  output logic        we3,
  output logic [4:0]  wa3,
  output logic [31:0] wd3,
  output logic [31:0] pend_mask,
  output logic        stall_req,
  output logic [31:0] drop_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

  typedef enum logic [1:0] {SRC_NONE, SRC_WB, SRC_MD, SRC_DBG} src_e;

  logic [4:0]    fifo_wa_q [FIFO_DEPTH];
  logic [31:0]   fifo_wd_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    wait_q, wait_d;
  logic          stall_req_q, stall_req_d;
  logic [31:0]   pend_mask_q, pend_mask_d;
  logic [31:0]   drop_count_q, drop_count_d;
  src_e          gnt;
  logic          fifo_nempty, push, pop, md_drop, dbg_drop;

  assign fifo_nempty = (count_q != '0);
  assign md_ready    = rst_n && (count_q != CW'(FIFO_DEPTH));
  assign push        = md_valid && md_ready && (md_wa != 5'd0);
  assign md_drop     = md_valid && md_ready && (md_wa == 5'd0);
  assign pop         = (gnt == SRC_MD);

`ifdef RF_ARB_DBG_PORT_EN
  logic rr_dbg_q, rr_dbg_d;  // 1: debug has the next contended turn
  logic dbg_req;
  assign dbg_req   = rst_n && dbg_valid && (dbg_wa != 5'd0);
  assign dbg_drop  = rst_n && dbg_valid && (dbg_wa == 5'd0);
  assign dbg_ready = dbg_drop || (gnt == SRC_DBG);
`else
  logic unused_dbg;
  assign unused_dbg = ^{dbg_valid, dbg_wa, dbg_wd};
  assign dbg_drop   = 1'b0;
  assign dbg_ready  = 1'b0;
`endif

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    gnt = SRC_NONE;
`ifdef RF_ARB_DBG_PORT_EN
    rr_dbg_d = rr_dbg_q;
`endif
    if (!rst_n) begin
      gnt = SRC_NONE;
    end else if (wb_we && (wb_wa != 5'd0)) begin
      gnt = SRC_WB;
    end else if (fifo_nempty && stall_req_q) begin
      gnt = SRC_MD;
`ifdef RF_ARB_DBG_PORT_EN
    end else if (fifo_nempty && dbg_req) begin
      gnt      = rr_dbg_q ? SRC_DBG : SRC_MD;
      rr_dbg_d = !rr_dbg_q;
    end else if (dbg_req) begin
      gnt = SRC_DBG;
`endif
    end else if (fifo_nempty) begin
      gnt = SRC_MD;
    end
  end

  always_comb begin
    we3 = 1'b0;
    wa3 = wb_wa;
    wd3 = wb_wd;
    case (gnt)
      SRC_WB: we3 = 1'b1;
      SRC_MD: begin
        we3 = 1'b1;
        wa3 = fifo_wa_q[rd_ptr_q];
        wd3 = fifo_wd_q[rd_ptr_q];
      end
`ifdef RF_ARB_DBG_PORT_EN
      SRC_DBG: begin
        we3 = 1'b1;
        wa3 = dbg_wa;
        wd3 = dbg_wd;
      end
`endif
      default: ;
    endcase
    if (!rst_n) begin
      wa3 = '0;
      wd3 = '0;
    end
  end

  always_comb begin
    rd_ptr_d     = rd_ptr_q + PW'(pop);
    wr_ptr_d     = wr_ptr_q + PW'(push);
    count_d      = count_q + CW'(push) - CW'(pop);
    drop_count_d = drop_count_q + 32'(md_drop) + 32'(dbg_drop);
    wait_d       = wait_q;
    if (pop) begin
      wait_d = '0;
    end else if (fifo_nempty && (wait_q < LIMIT)) begin
      wait_d = wait_q + 8'd1;
    end
    stall_req_d = !pop && (wait_d >= LIMIT);
    // Mask reflects the entries that will be live after this edge's push/pop.
    pend_mask_d = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (CW'(PW'(PW'(i) - rd_ptr_d)) < count_d) begin
        if (push && (wr_ptr_q == PW'(i))) begin
          pend_mask_d = pend_mask_d | (32'd1 << md_wa);
        end else begin
          pend_mask_d = pend_mask_d | (32'd1 << fifo_wa_q[i]);
        end
      end
    end
  end

  // NOTE: the payload arrays carry no reset; the pointers and count alone decide validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wa_q[wr_ptr_q] <= md_wa;
      fifo_wd_q[wr_ptr_q] <= md_wd;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      wait_q       <= '0;
      stall_req_q  <= 1'b0;
      pend_mask_q  <= '0;
      drop_count_q <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      wait_q       <= wait_d;
      stall_req_q  <= stall_req_d;
      pend_mask_q  <= pend_mask_d;
      drop_count_q <= drop_count_d;
    end
  end

`ifdef RF_ARB_DBG_PORT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_dbg_q <= 1'b0;
    else        rr_dbg_q <= rr_dbg_d;
  end
`endif

  assign pend_mask  = pend_mask_q;
  assign stall_req  = stall_req_q;
  assign drop_count = drop_count_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && stall_req_q && wb_we)
      $error("rf_write_arbiter: wb_we asserted while stall_req is high");
  end
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed scenarios plus randomized traffic, all checked
// each cycle against a queue-based model of the arbitration rules.
module tb_rf_write_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
`ifdef RF_ARB_DBG_PORT_EN
  localparam bit DBG_EN = 1'b1;
`else
  localparam bit DBG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we, md_valid, dbg_valid;
  logic [4:0]  wb_wa, md_wa, dbg_wa;
  logic [31:0] wb_wd, md_wd, dbg_wd;
  logic        md_ready, dbg_ready, we3, stall_req;
  logic [4:0]  wa3;
  logic [31:0] wd3, pend_mask, drop_count;

  always #5 clk = ~clk;

  rf_write_arbiter #(.FIFO_DEPTH(DEPTH), .STALL_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .md_valid(md_valid), .md_ready(md_ready), .md_wa(md_wa), .md_wd(md_wd),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_wa(dbg_wa), .dbg_wd(dbg_wd),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .pend_mask(pend_mask), .stall_req(stall_req), .drop_count(drop_count)
  );

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } ent_t;

  ent_t        q[$];
  int          m_wait;
  bit          m_stall, m_rr_dbg;
  logic [31:0] m_drop;

  int          e_src;  // 0 none, 1 wb, 2 fifo head, 3 debug
  bit          e_contend, e_md_ready, e_dbg_ready;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_wait   = 0;
    m_stall  = 1'b0;
    m_rr_dbg = 1'b0;
    m_drop   = '0;
  endtask

  task automatic model_eval();
    bit          wb_w, head, dbgr;
    logic [4:0]  x_wa;
    logic [31:0] x_wd, pm;
    wb_w = wb_we && (wb_wa != 0);
    head = q.size() > 0;
    dbgr = DBG_EN && dbg_valid && (dbg_wa != 0);
    e_contend = 1'b0;
    if (wb_w)                 e_src = 1;
    else if (head && m_stall) e_src = 2;
    else if (head && dbgr) begin
      e_src = m_rr_dbg ? 3 : 2;
      e_contend = 1'b1;
    end
    else if (head)            e_src = 2;
    else if (dbgr)            e_src = 3;
    else                      e_src = 0;
    x_wa = wb_wa;
    x_wd = wb_wd;
    if (e_src == 2) begin x_wa = q[0].wa; x_wd = q[0].wd; end
    if (e_src == 3) begin x_wa = dbg_wa;  x_wd = dbg_wd;  end
    e_md_ready  = q.size() < DEPTH;
    e_dbg_ready = DBG_EN && dbg_valid && ((dbg_wa == 0) || (e_src == 3));
    pm = '0;
    foreach (q[i]) pm[q[i].wa] = 1'b1;
    check("we3", 32'(we3), 32'(e_src != 0));
    check("wa3", 32'(wa3), 32'(x_wa));
    check("wd3", wd3, x_wd);
    check("md_ready", 32'(md_ready), 32'(e_md_ready));
    check("dbg_ready", 32'(dbg_ready), 32'(e_dbg_ready));
    check("pend_mask", pend_mask, pm);
    check("stall_req", 32'(stall_req), 32'(m_stall));
    check("drop_count", drop_count, m_drop);
  endtask

  task automatic model_update();
    bit   popped, was_busy;
    ent_t e;
    popped   = (e_src == 2);
    was_busy = q.size() > 0;
    if (popped) void'(q.pop_front());
    if (md_valid && e_md_ready) begin
      if (md_wa != 0) begin
        e.wa = md_wa;
        e.wd = md_wd;
        q.push_back(e);
      end else begin
        m_drop++;
      end
    end
    if (DBG_EN && dbg_valid && (dbg_wa == 0)) m_drop++;
    if (e_contend) m_rr_dbg = !m_rr_dbg;
    if (popped)        m_wait = 0;
    else if (was_busy) m_wait++;
    m_stall = !popped && (m_wait >= LIMIT);
  endtask

  task automatic eval_half();
    @(negedge clk);
    model_eval();
  endtask

  task automatic end_cycle();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    eval_half();
    end_cycle();
  endtask

  task automatic idle();
    wb_we = 0; wb_wa = 0; wb_wd = 0;
    md_valid = 0; md_wa = 0; md_wd = 0;
    dbg_valid = 0; dbg_wa = 0; dbg_wd = 0;
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 1'b0;
    wb_we = 1; wb_wa = 5'd5; wb_wd = 32'h1234_5678;
    #1;
    check("rst_we3", 32'(we3), 0);
    check("rst_wa3", 32'(wa3), 0);
    check("rst_wd3", wd3, 0);
    check("rst_md_ready", 32'(md_ready), 0);
    check("rst_dbg_ready", 32'(dbg_ready), 0);
    check("rst_pend", pend_mask, 0);
    check("rst_stall", 32'(stall_req), 0);
    check("rst_drop", drop_count, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    #1;
    check("rel_md_ready", 32'(md_ready), 1);

    // WB passthrough
    wb_we = 1; wb_wa = 5'd5; wb_wd = 32'hDEAD_BEEF;
    eval_half();
    check("wb_we3", 32'(we3), 1);
    check("wb_wa3", 32'(wa3), 5);
    check("wb_wd3", wd3, 32'hDEAD_BEEF);
    check("wb_pend", pend_mask, 0);
    end_cycle();

    // md buffering behind a busy WB until stall_req
    wb_wa = 5'd1; wb_wd = 32'hA5A5_0001;
    md_valid = 1; md_wa = 5'd7; md_wd = 32'h11;
    cyc();
    md_valid = 0;
    check("buf_pend", pend_mask, 32'h80);
    for (int k = 0; k < LIMIT; k++) begin
      check("buf_stall_early", 32'(stall_req), 0);
      cyc();
    end
    check("buf_stall", 32'(stall_req), 1);
    wb_we = 0;
    eval_half();
    check("buf_we3", 32'(we3), 1);
    check("buf_wa3", 32'(wa3), 7);
    check("buf_wd3", wd3, 32'h11);
    end_cycle();
    check("buf_pend_clr", pend_mask, 0);
    check("buf_stall_clr", 32'(stall_req), 0);

    // WB to $0: no write, no drop
    wb_we = 1; wb_wa = 5'd0; wb_wd = 32'h55;
    eval_half();
    check("wb0_we3", 32'(we3), 0);
    end_cycle();
    check("wb0_drop", drop_count, 0);

    // FIFO full, third push waits for the cycle after a pop
    wb_wa = 5'd2;
    md_valid = 1; md_wa = 5'd8; md_wd = 32'd1;
    cyc();
    md_wa = 5'd9; md_wd = 32'd2;
    cyc();
    check("full_ready", 32'(md_ready), 0);
    check("full_pend", pend_mask, 32'h300);
    md_wa = 5'd10; md_wd = 32'd3;
    cyc();
    wb_we = 0;
    eval_half();
    check("full_nobypass", 32'(md_ready), 0);
    check("full_pop_wa3", 32'(wa3), 8);
    end_cycle();
    check("full_ready_after", 32'(md_ready), 1);
    cyc();
    md_valid = 0;
    check("full_pend_after", pend_mask, 32'h400);
    cyc();
    check("full_drained", pend_mask, 0);

`ifdef RF_ARB_DBG_PORT_EN
    // Round-robin: head first, then debug
    wb_we = 1; wb_wa = 5'd1;
    md_valid = 1; md_wa = 5'd3; md_wd = 32'h33;
    cyc();
    md_valid = 0; wb_we = 0;
    dbg_valid = 1; dbg_wa = 5'd4; dbg_wd = 32'h44;
    eval_half();
    check("rr_first", 32'(wa3), 3);
    check("rr_first_dbg", 32'(dbg_ready), 0);
    end_cycle();
    eval_half();
    check("rr_second", 32'(wa3), 4);
    check("rr_second_dbg", 32'(dbg_ready), 1);
    end_cycle();
    dbg_valid = 0;
`endif

    // $0 drops from md and dbg in one cycle
    idle();
    md_valid = 1; md_wa = 5'd0; md_wd = 32'h9;
    dbg_valid = 1; dbg_wa = 5'd0; dbg_wd = 32'h7;
    eval_half();
    check("drop_we3", 32'(we3), 0);
`ifdef RF_ARB_DBG_PORT_EN
    check("drop_dbg_ready", 32'(dbg_ready), 1);
`endif
    end_cycle();
`ifdef RF_ARB_DBG_PORT_EN
    check("drop_count2", drop_count, 2);
`else
    check("drop_count1", drop_count, 1);
`endif

    // Reset mid-operation
    idle();
    wb_we = 1; wb_wa = 5'd1;
    md_valid = 1; md_wa = 5'd12; md_wd = 32'hC;
    cyc();
    md_wa = 5'd13; md_wd = 32'hD;
    cyc();
    md_valid = 0;
    check("mid_pend", pend_mask, 32'h3000);
    rst_n = 1'b0;
    #1;
    check("mid_pend_rst", pend_mask, 0);
    check("mid_ready_rst", 32'(md_ready), 0);
    check("mid_stall_rst", 32'(stall_req), 0);
    check("mid_we3_rst", 32'(we3), 0);
    check("mid_drop_rst", drop_count, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    #1;
    check("mid_ready_rel", 32'(md_ready), 1);

    // Randomized traffic at three WB load levels
    for (int p = 0; p < 3; p++) begin
      int busy;
      busy = (p == 0) ? 90 : (p == 1) ? 55 : 15;
      for (int c = 0; c < 1000; c++) begin
        wb_we    = ($urandom_range(0, 99) < busy) && !m_stall;
        wb_wa    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        wb_wd    = $urandom;
        md_valid = $urandom_range(0, 99) < 45;
        md_wa    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 4));
        md_wd    = $urandom;
        if (!dbg_valid && ($urandom_range(0, 99) < 25)) begin
          dbg_valid = 1;
          dbg_wa    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
          dbg_wd    = $urandom;
        end
        cyc();
        if (e_dbg_ready) dbg_valid = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
